muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit for the MIPS execute stage. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers. The decode/control path issues an op with a one-cycle `start`, then stalls the pipeline on `busy`. The unit pulses `done` when HI/LO hold the new result.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. The datapath is built for 32; other values are not supported.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  issue strobe; sampled only in IDLE.
- `md_op`  in  3  operation select:
  - 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
  - 111 is reserved and treated as NONE.
- `rs_val`  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- `rt_val`  in  WIDTH  multiplier / divisor.
- `busy`  out  1  high while a mul/div is in flight.
- `done`  out  1  one-cycle pulse; HI/LO are updated and visible in this cycle.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
States: IDLE, MUL, DIV, SIGN.

**IDLE**
- `start`=1 with MULT/MULTU:
  - latch operand magnitudes and the sign-fix flags;
  - clear the iteration counter;
  - go to MUL.
- `start`=1 with DIV/DIVU: same latching, go to DIV.
- `start`=1 with MTHI: `hi` <= `rs_val` at this edge. No `busy`, no `done`, stay in IDLE.
- `start`=1 with MTLO: same as MTHI, but writes `lo`.
- `start`=1 with NONE or 111: no effect.

**Operand prep**
- Signed ops (MULT, DIV) convert each negative operand to its two's-complement magnitude, held as unsigned WIDTH bits. 8000_0000 stays 8000_0000, interpreted as 2^31.
- Unsigned ops use the operands as-is and clear the sign flags.

**MUL**
- Shift-add, one multiplier bit per cycle, LSB first.
- 2*WIDTH-bit internal product accumulator.
- Exactly WIDTH cycles, then go to SIGN.

**DIV**
- Restoring division, one quotient bit per cycle, MSB first.
- WIDTH+1-bit partial remainder.
- Exactly WIDTH cycles, then go to SIGN.

**SIGN** (one cycle)
- Product: negated as 64 bits if the operand signs differ (signed op only).
- Quotient: negated if the dividend and divisor signs differ.
- Remainder: takes the sign of the dividend.
- Writes `hi` = product[63:32] or remainder, and `lo` = product[31:0] or quotient. Returns to IDLE.

**Rules**
- `hi`/`lo` hold their old values throughout MUL/DIV; only SIGN writes them.
- Divide by zero, signed or unsigned: `lo`=FFFF_FFFF, `hi`=`rs_val` as issued. Full latency, `done` still pulses.
- Signed overflow 8000_0000 / FFFF_FFFF: `lo`=8000_0000, `hi`=0000_0000.
- `start` while `busy`: ignored entirely, including MTHI/MTLO. The issuer must stall.
- `md_op`, `rs_val` and `rt_val` only need to be valid in the `start` cycle.

## Timing
- Reset (`rst_n`=0 at a rising edge), including mid-operation:
  - state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0;
  - internal accumulator and counter are cleared;
  - an in-flight result is discarded.
- Mul/div accepted at edge 0 (the `start` cycle is cycle 0):
  - `busy`=1 in cycles 1..WIDTH+1 (33 cycles: WIDTH iterations plus SIGN);
  - cycle WIDTH+2 (cycle 34): `busy`=0, `done`=1, new `hi`/`lo` visible;
  - the next `start` can be accepted in cycle 34.
- MTHI/MTLO in cycle 0: new value visible in cycle 1. A `start` in cycle 1 is accepted.
- `done` is registered and is never high for two consecutive cycles.
- Latency is data-independent. There is no early termination.

## Test plan
- **MULTU, max operands:** `rs`=FFFF_FFFF, `rt`=FFFF_FFFF.
  - -> `hi`=FFFF_FFFE, `lo`=0000_0001.
  - -> `busy` high for exactly 33 cycles; `done` pulses once in cycle 34.
- **MULT, mixed signs:** `rs`=FFFF_FFFD (-3), `rt`=0000_0007.
  - -> `hi`=FFFF_FFFF, `lo`=FFFF_FFEB (-21).
- **DIV vs DIVU:** DIV `rs`=FFFF_FFF9 (-7), `rt`=2 -> `lo`=FFFF_FFFD, `hi`=FFFF_FFFF. DIVU `rs`=7, `rt`=2 -> `lo`=3, `hi`=1.
- **Divide corner cases:**
  - DIV 8000_0000 / FFFF_FFFF -> `lo`=8000_0000, `hi`=0.
  - DIVU 0000_1234 / 0 -> `lo`=FFFF_FFFF, `hi`=0000_1234, with the full 34-cycle latency.
- **Moves and issue-while-busy:**
  - MTHI `rs`=AAAA_5555, then MTLO `rs`=1234_5678 on consecutive cycles -> `hi`/`lo` update the cycle after each, with no `busy` and no `done`.
  - MULT issued, then MTHI with `start` in cycle 5 -> the MTHI is ignored and the final `hi` is the product's.
- **Reset mid-operation:**
  - `rst_n`=0 in cycle 10 of a DIVU -> next cycle `busy`=0, `done`=0, `hi`=`lo`=0, and no `done` pulse ever appears for the aborted op.
  - A following MULTU 3*5 completes normally -> `lo`=F, `hi`=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit for the MIPS execute stage. Implements MULT,
// MULTU, DIV, DIVU, MTHI and MTLO and owns the architectural HI/LO registers.
// Multiplication is shift-add (one multiplier bit per cycle, LSB first);
// division is restoring (one quotient bit per cycle, MSB first). Both run on
// operand magnitudes and fix the signs in a final one-cycle SIGN state, so the
// latency is WIDTH iterations + SIGN regardless of the data.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst_n   in   1      synchronous active-low reset
//   start   in   1      issue strobe, sampled only while idle
//   md_op   in   3      000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                       101 MTHI, 110 MTLO, 111 reserved (NONE)
//   rs_val  in   WIDTH  multiplicand / dividend / MTHI-MTLO source
//   rt_val  in   WIDTH  multiplier / divisor
//   busy    out  1      high while a mul/div is in flight
//   done    out  1      one-cycle pulse, new HI/LO visible in the same cycle
//   hi      out  WIDTH  HI register
//   lo      out  WIDTH  LO register
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_SIGN = 2'd3
    } state_e;

    state_e           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    // MUL: full product accumulator {partial sum, remaining multiplier bits}.
    // DIV: low half is the dividend shifting out / quotient shifting in.
    logic [PW-1:0]    acc_q,    acc_d;
    logic [WIDTH-1:0] rem_q,    rem_d;     // partial remainder between steps
    logic [WIDTH-1:0] opnd_q,   opnd_d;    // multiplicand or divisor magnitude
    logic             neg_a_q,  neg_a_d;   // rs operand was negative (signed op)
    logic             neg_b_q,  neg_b_d;   // rt operand was negative (signed op)
    logic             is_div_q, is_div_d;
    logic             dz_q,     dz_d;      // divide by zero
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic             done_q,   done_d;

    // Operand preparation (used only in the accepting cycle)
    logic             signed_op;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    // Iteration datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic             div_ok;
    logic [WIDTH-1:0] div_sub;
    logic             last_iter;

    // Sign fix-up
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        signed_op = (md_op == OP_MULT) || (md_op == OP_DIV);
        rs_neg    = signed_op && rs_val[WIDTH-1];
        rt_neg    = signed_op && rt_val[WIDTH-1];
        // 8000_0000 negates to itself and is then read as the unsigned 2^31.
        rs_mag    = rs_neg ? (~rs_val + WIDTH'(1)) : rs_val;
        rt_mag    = rt_neg ? (~rt_val + WIDTH'(1)) : rt_val;

        // Shift-add: add the multiplicand into the upper half when the current
        // multiplier bit (acc LSB) is set, then shift the whole accumulator.
        mul_sum   = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        // Restoring step on the WIDTH+1-bit shifted remainder. The low WIDTH
        // bits of the difference are exact whenever the subtraction is kept,
        // because the result is then below the divisor.
        rem_shift = {rem_q, acc_q[WIDTH-1]};
        div_ok    = rem_shift >= {1'b0, opnd_q};
        div_sub   = rem_shift[WIDTH-1:0] - opnd_q;

        last_iter = (cnt_q == CW'(WIDTH - 1));

        prod_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q + PW'(1)) : acc_q;
        quot_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q[WIDTH-1:0] + WIDTH'(1))
                                        : acc_q[WIDTH-1:0];
        rem_fix   = neg_a_q ? (~rem_q + WIDTH'(1)) : rem_q;
    end

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so
        // no branch below can leave a signal unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (md_op)
                        OP_MULT, OP_MULTU: begin
                            acc_d    = {WIDTH'(0), rt_mag};
                            opnd_d   = rs_mag;
                            neg_a_d  = rs_neg;
                            neg_b_d  = rt_neg;
                            is_div_d = 1'b0;
                            dz_d     = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d    = {WIDTH'(0), rs_mag};
                            rem_d    = '0;
                            opnd_d   = rt_mag;
                            neg_a_d  = rs_neg;
                            neg_b_d  = rt_neg;
                            is_div_d = 1'b1;
                            dz_d     = (rt_val == '0);
                            cnt_d    = '0;
                            state_d  = S_DIV;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;   // NONE and reserved encoding
                    endcase
                end
            end

            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = S_SIGN;
                end
            end

            S_DIV: begin
                rem_d = div_ok ? div_sub : rem_shift[WIDTH-1:0];
                acc_d = {acc_q[PW-1:WIDTH], acc_q[WIDTH-2:0], div_ok};
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = S_SIGN;
                end
            end

            S_SIGN: begin
                if (is_div_q) begin
                    // With a zero divisor every trial subtraction succeeds, so
                    // the remainder is |rs|; restoring the dividend's sign
                    // therefore yields rs as issued. Only LO needs forcing.
                    hi_d = rem_fix;
                    lo_d = dz_q ? '1 : quot_fix;
                end else begin
                    hi_d = prod_fix[PW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset along with the control
            // state, so an aborted op leaves no residue in accumulator/counter.
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
